// File: rtl/mem_port_arbiter_if.sv
// Bundles the per-master request/response bus and the single memory port
// between the arbiter and its masters and memory.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_MASTERS = 3
);
  logic [NUM_MASTERS-1:0]            m_req;
  logic [NUM_MASTERS-1:0]            m_we;
  logic [NUM_MASTERS-1:0]            m_lock;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]            m_ack;
  logic [NUM_MASTERS-1:0]            m_rvalid;
  logic [DATA_WIDTH-1:0]             m_rdata;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic [DATA_WIDTH-1:0]             mem_wdata;
  logic                              mem_we;
  logic [DATA_WIDTH-1:0]             mem_rdata;

  modport slave (
    input  m_req, m_we, m_lock, m_addr, m_wdata, mem_rdata,
    output m_ack, m_rvalid, m_rdata, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output m_req, m_we, m_lock, m_addr, m_wdata, mem_rdata,
    input  m_ack, m_rvalid, m_rdata, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-master arbiter in front of one single-port synchronous RAM: round-robin or
// fixed-priority grant, lock for read-modify-write, in-order read-return tagging.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_MASTERS  = 3,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [IW-1:0]           rr_q, rr_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic                    owner_vld_q, owner_vld_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NUM_MASTERS-1:0]  tag_q [READ_LATENCY];
  logic [NUM_MASTERS-1:0]  tag_d [READ_LATENCY];

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_MASTERS];
  logic                    grant_vld;
  logic                    locked_grant;
  logic [IW-1:0]           grant_idx;
  logic [NUM_MASTERS-1:0]  ack;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = bus.m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Grant selection: a requesting lock owner always wins over the arbitration policy.
  always_comb begin
    grant_vld    = 1'b0;
    locked_grant = 1'b0;
    grant_idx    = '0;
    if (owner_vld_q && bus.m_req[owner_q]) begin
      grant_vld    = 1'b1;
      locked_grant = 1'b1;
      grant_idx    = owner_q;
    end else if (ARB_MODE == 1) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (bus.m_req[i]) begin
          grant_vld = 1'b1;
          grant_idx = IW'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!grant_vld && bus.m_req[(int'(rr_q) + i) % NUM_MASTERS]) begin
          grant_vld = 1'b1;
          grant_idx = IW'((int'(rr_q) + i) % NUM_MASTERS);
        end
      end
    end
  end

  always_comb begin
    ack         = '0;
    rr_d        = rr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    for (int i = 0; i < READ_LATENCY; i++) begin
      tag_d[i] = (i == 0) ? '0 : tag_q[(i == 0) ? 0 : i - 1];
    end

    if (owner_vld_q && !bus.m_req[owner_q]) begin
      owner_vld_d = 1'b0;
    end

    if (grant_vld) begin
      ack[grant_idx] = 1'b1;
      mem_addr_d     = addr_arr[grant_idx];
      mem_wdata_d    = wdata_arr[grant_idx];
      if (!bus.m_we[grant_idx]) begin
        tag_d[0] = ack;
      end
      if (!locked_grant) begin
        rr_d = (int'(grant_idx) == NUM_MASTERS - 1) ? '0 : grant_idx + IW'(1);
      end
      if (bus.m_lock[grant_idx]) begin
        owner_vld_d = 1'b1;
        owner_d     = grant_idx;
      end else if (locked_grant) begin
        owner_vld_d = 1'b0;
      end
    end

    // Outputs are forced quiet while reset is held, including in-flight read tags.
    bus.m_ack     = reset ? '0 : ack;
    bus.m_rvalid  = reset ? '0 : tag_q[READ_LATENCY-1];
    bus.m_rdata   = reset ? '0 : bus.mem_rdata;
    bus.mem_we    = reset ? 1'b0 : (grant_vld && bus.m_we[grant_idx]);
    bus.mem_addr  = reset ? '0 : mem_addr_d;
    bus.mem_wdata = reset ? '0 : mem_wdata_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q        <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_tag_pipe
    always_ff @(posedge clock) begin
      if (reset) begin
        tag_q[gi] <= '0;
      end else begin
        tag_q[gi] <= tag_d[gi];
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a round-robin instance with 2-cycle read latency and a
// fixed-priority instance with 1-cycle latency, each with a small RAM model.
module tb_mem_port_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_MASTERS(3)) bus_a ();
  mem_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_MASTERS(3)) bus_b ();

  mem_port_arbiter #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_MASTERS(3), .READ_LATENCY(2), .ARB_MODE(0)
  ) dut_rr (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  mem_port_arbiter #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_MASTERS(3), .READ_LATENCY(1), .ARB_MODE(1)
  ) dut_fp (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  // RAM model with preset contents; writable only through dut_rr.
  logic [15:0] ram [65536];
  logic [15:0] rd_a1, rd_a2, rd_b1;

  always @(posedge clock) begin
    if (reset) begin
      ram[16'h0010] <= 16'hAAAA;
      ram[16'h0020] <= 16'h5555;
      ram[16'h0030] <= 16'h0BAD;
      ram[16'h0060] <= 16'h6060;
      ram[16'h0070] <= 16'h7070;
    end else if (bus_a.mem_we) begin
      ram[bus_a.mem_addr] <= bus_a.mem_wdata;
    end
    rd_a1 <= ram[bus_a.mem_addr];
    rd_a2 <= rd_a1;
    rd_b1 <= ram[bus_b.mem_addr];
  end

  assign bus_a.mem_rdata = rd_a2;
  assign bus_b.mem_rdata = rd_b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("check %s: got=%h ok", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_a();
    bus_a.m_req = '0; bus_a.m_we = '0; bus_a.m_lock = '0;
    bus_a.m_addr = '0; bus_a.m_wdata = '0;
  endtask

  task automatic clear_b();
    bus_b.m_req = '0; bus_b.m_we = '0; bus_b.m_lock = '0;
    bus_b.m_addr = '0; bus_b.m_wdata = '0;
  endtask

  task automatic set_a(input int i, input logic we, input logic lock,
                       input logic [15:0] a, input logic [15:0] d);
    bus_a.m_req[i]           = 1'b1;
    bus_a.m_we[i]            = we;
    bus_a.m_lock[i]          = lock;
    bus_a.m_addr[i*16 +: 16]  = a;
    bus_a.m_wdata[i*16 +: 16] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_a();
    clear_b();
    // Requests present during reset must not leak through.
    set_a(0, 1'b1, 1'b0, 16'h1111, 16'hA1A1);
    set_a(1, 1'b1, 1'b0, 16'h2222, 16'hB2B2);
    set_a(2, 1'b1, 1'b0, 16'h3333, 16'hC3C3);
    step(); step();
    @(negedge clock);
    check_eq("rst_ack",    32'(bus_a.m_ack),     32'h0);
    check_eq("rst_rvalid", 32'(bus_a.m_rvalid),  32'h0);
    check_eq("rst_we",     32'(bus_a.mem_we),    32'h0);
    check_eq("rst_addr",   32'(bus_a.mem_addr),  32'h0);
    check_eq("rst_wdata",  32'(bus_a.mem_wdata), 32'h0);
    check_eq("rst_rdata",  32'(bus_a.m_rdata),   32'h0);
    step();
    reset = 1'b0;
    clear_a();

    // Reset mid-read: m1 read, then reset next cycle.
    set_a(1, 1'b0, 1'b0, 16'h0040, 16'h0);
    @(negedge clock);
    check_eq("t1_ack", 32'(bus_a.m_ack), 32'b010);
    step();
    reset = 1'b1;
    clear_a();
    @(negedge clock);
    check_eq("t1_rvalid_in_rst", 32'(bus_a.m_rvalid), 32'h0);
    step();
    reset = 1'b0;

    // Round-robin with all requesting; first ack 001 proves rr was cleared.
    set_a(0, 1'b0, 1'b0, 16'h0010, 16'h0);
    set_a(1, 1'b0, 1'b0, 16'h0020, 16'h0);
    set_a(2, 1'b0, 1'b0, 16'h0030, 16'h0);
    @(negedge clock);
    check_eq("t1_rvalid_after", 32'(bus_a.m_rvalid), 32'h0);
    check_eq("t2_ack0", 32'(bus_a.m_ack), 32'b001);
    for (int k = 1; k < 6; k++) begin
      step();
      @(negedge clock);
      check_eq($sformatf("t2_ack%0d", k), 32'(bus_a.m_ack), 32'(3'b001 << (k % 3)));
    end
    step();
    clear_a();
    step(); step(); step();

    // Read ordering with 2-cycle latency.
    set_a(0, 1'b0, 1'b0, 16'h0010, 16'h0);
    @(negedge clock);
    check_eq("t4_ack_m0", 32'(bus_a.m_ack), 32'b001);
    step();
    clear_a();
    set_a(2, 1'b0, 1'b0, 16'h0020, 16'h0);
    @(negedge clock);
    check_eq("t4_ack_m2", 32'(bus_a.m_ack), 32'b100);
    step();
    clear_a();
    @(negedge clock);
    check_eq("t4_rvalid0", 32'(bus_a.m_rvalid), 32'b001);
    check_eq("t4_rdata0",  32'(bus_a.m_rdata),  32'hAAAA);
    step();
    @(negedge clock);
    check_eq("t4_rvalid1", 32'(bus_a.m_rvalid), 32'b100);
    check_eq("t4_rdata1",  32'(bus_a.m_rdata),  32'h5555);
    step();
    @(negedge clock);
    check_eq("t4_rvalid_end", 32'(bus_a.m_rvalid), 32'h0);

    // Lock RMW: move rr to m1 with one m0 write, then m1 read-lock / write-unlock.
    step();
    set_a(0, 1'b1, 1'b0, 16'h0050, 16'h0000);
    @(negedge clock);
    check_eq("t5_ack_pre", 32'(bus_a.m_ack), 32'b001);
    step();
    clear_a();
    set_a(0, 1'b0, 1'b0, 16'h0060, 16'h0);
    set_a(1, 1'b0, 1'b1, 16'h0030, 16'h0);
    set_a(2, 1'b0, 1'b0, 16'h0070, 16'h0);
    @(negedge clock);
    check_eq("t5_ack_rd", 32'(bus_a.m_ack), 32'b010);
    step();
    set_a(1, 1'b1, 1'b0, 16'h0030, 16'h1234);
    @(negedge clock);
    check_eq("t5_ack_wr", 32'(bus_a.m_ack),     32'b010);
    check_eq("t5_we",     32'(bus_a.mem_we),    32'h1);
    check_eq("t5_addr",   32'(bus_a.mem_addr),  32'h0030);
    check_eq("t5_wdata",  32'(bus_a.mem_wdata), 32'h1234);
    step();
    bus_a.m_req[1] = 1'b0;
    @(negedge clock);
    check_eq("t5_ack_m2",  32'(bus_a.m_ack),    32'b100);
    check_eq("t5_rvalid",  32'(bus_a.m_rvalid), 32'b010);
    check_eq("t5_rdata",   32'(bus_a.m_rdata),  32'h0BAD);
    step();
    bus_a.m_req[2] = 1'b0;
    @(negedge clock);
    check_eq("t5_ack_m0", 32'(bus_a.m_ack), 32'b001);
    step();
    clear_a();
    @(negedge clock);
    check_eq("t5_ram",       32'(ram[16'h0030]),  32'h1234);
    check_eq("t5_rvalid_m2", 32'(bus_a.m_rvalid), 32'b100);
    check_eq("t5_rdata_m2",  32'(bus_a.m_rdata),  32'h7070);
    step();
    @(negedge clock);
    check_eq("t5_rvalid_m0", 32'(bus_a.m_rvalid), 32'b001);
    check_eq("t5_rdata_m0",  32'(bus_a.m_rdata),  32'h6060);
    step(); step();

    // Write pass-through, then hold of address/data while idle.
    set_a(2, 1'b1, 1'b0, 16'h00FF, 16'hBEEF);
    @(negedge clock);
    check_eq("t6_ack",   32'(bus_a.m_ack),     32'b100);
    check_eq("t6_we",    32'(bus_a.mem_we),    32'h1);
    check_eq("t6_addr",  32'(bus_a.mem_addr),  32'h00FF);
    check_eq("t6_wdata", 32'(bus_a.mem_wdata), 32'hBEEF);
    step();
    clear_a();
    @(negedge clock);
    check_eq("t6_idle_we",    32'(bus_a.mem_we),    32'h0);
    check_eq("t6_hold_addr",  32'(bus_a.mem_addr),  32'h00FF);
    check_eq("t6_hold_wdata", 32'(bus_a.mem_wdata), 32'hBEEF);
    check_eq("t6_rvalid1",    32'(bus_a.m_rvalid),  32'h0);
    step();
    @(negedge clock);
    check_eq("t6_rvalid2", 32'(bus_a.m_rvalid), 32'h0);

    // Fixed priority on the second instance.
    step();
    bus_b.m_req  = 3'b110;
    bus_b.m_addr = {16'h0000, 16'h0010, 16'h0020};
    @(negedge clock);
    check_eq("t3_ack_110", 32'(bus_b.m_ack), 32'b010);
    step();
    bus_b.m_req = 3'b111;
    @(negedge clock);
    check_eq("t3_ack_111", 32'(bus_b.m_ack),    32'b001);
    check_eq("t3_rvalid1", 32'(bus_b.m_rvalid), 32'b010);
    check_eq("t3_rdata1",  32'(bus_b.m_rdata),  32'hAAAA);
    step();
    clear_b();
    @(negedge clock);
    check_eq("t3_rvalid0", 32'(bus_b.m_rvalid), 32'b001);
    check_eq("t3_rdata0",  32'(bus_b.m_rdata),  32'h5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
